// File: rtl/bb_sgpio_pkg.sv
// Shared definitions for the baseboard SGPIO frame controller: FSM states,
// per-drive bit layout and parameter defaults.
package bb_sgpio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } sgpio_state_e;

  localparam int BITS_PER_DRV = 3;
  localparam int ACT_OFS      = 0;
  localparam int LOC_OFS      = 1;
  localparam int FAIL_OFS     = 2;

  localparam int DEF_HDD_NUM      = 36;
  localparam int DEF_CLK_DIV      = 250;
  localparam int DEF_BLINK_FRAMES = 8;

  // Position of one LED bit of one drive inside the serial frame.
  function automatic int drv_bit(input int drv, input int ofs);
    return drv * BITS_PER_DRV + ofs;
  endfunction

endpackage

// File: rtl/bb_sgpio_clkgen.sv
// SGPIO clock divider: toggles sgpio_ck every CLK_DIV system clocks and flags
// the system-clock cycle just before each SGPIO clock edge.
module bb_sgpio_clkgen
  import bb_sgpio_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic sgpio_ck,
  output logic tick_rise,
  output logic tick_fall
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_d, div_q;
  logic             ck_d, ck_q;
  logic             div_wrap;

  always_comb begin
    div_wrap = (div_q == DIV_LAST);
    div_d    = div_q + DIV_W'(1);
    ck_d     = ck_q;
    if (div_wrap) begin
      div_d = '0;
      ck_d  = ~ck_q;
    end else begin
      ck_d  = ck_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      ck_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ck_q  <= ck_d;
    end
  end

  // The ticks lead the registered clock edge by one cycle so that the
  // sequencer's own registers change on the same edge as sgpio_ck.
  assign sgpio_ck  = ck_q;
  assign tick_rise = div_wrap & ~ck_q;
  assign tick_fall = div_wrap & ck_q;

endmodule

// File: rtl/bb_sgpio_ctrl.sv
// SGPIO frame controller: snapshots drive LED state with sticky activity,
// locate blink and global enable/lamp test, then shifts it out MSB-last.
module bb_sgpio_ctrl
  import bb_sgpio_pkg::*;
#(
  parameter int HDD_NUM      = DEF_HDD_NUM,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic               SYSCLK,
  input  logic               RESET,
  input  logic [HDD_NUM-1:0] DRV_ACT,
  input  logic [HDD_NUM-1:0] DRV_LOCATE,
  input  logic [HDD_NUM-1:0] DRV_FAIL,
  input  logic               LED_EN,
  input  logic               LAMP_TEST,
  output logic               SGPIO_CK,
  output logic               SGPIO_LD,
  output logic               SGPIO_DATA,
  output logic               FRAME_DONE,
  output logic [15:0]        FRAME_CNT
);

  localparam int NBITS = BITS_PER_DRV * HDD_NUM;
  localparam int IDX_W = $clog2(NBITS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  logic tick_fall;
  logic unused_tick_rise;

  sgpio_state_e     state_d, state_q;
  logic [NBITS-1:0] shreg_d, shreg_q;
  logic [IDX_W-1:0] bit_idx_d, bit_idx_q;
  logic [HDD_NUM-1:0] acc_d, acc_q;
  logic [BLK_W-1:0] blink_cnt_d, blink_cnt_q;
  logic             blink_phase_d, blink_phase_q;
  logic             data_d, data_q;
  logic             ld_d, ld_q;
  logic             done_d, done_q;
  logic [15:0]      frame_cnt_d, frame_cnt_q;

  logic [NBITS-1:0] snap_raw;
  logic [NBITS-1:0] snap_bits;

  bb_sgpio_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk       (SYSCLK),
    .rst       (RESET),
    .sgpio_ck  (SGPIO_CK),
    .tick_rise (unused_tick_rise),
    .tick_fall (tick_fall)
  );

  for (genvar g = 0; g < HDD_NUM; g++) begin : g_drv
    assign snap_raw[drv_bit(g, ACT_OFS)]  = acc_q[g] | DRV_ACT[g];
    assign snap_raw[drv_bit(g, LOC_OFS)]  = DRV_LOCATE[g] & blink_phase_q;
    assign snap_raw[drv_bit(g, FAIL_OFS)] = DRV_FAIL[g];
  end

  // Lamp test outranks the global enable.
  always_comb begin
    if (LAMP_TEST) begin
      snap_bits = '1;
    end else if (!LED_EN) begin
      snap_bits = '0;
    end else begin
      snap_bits = snap_raw;
    end
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_idx_d     = bit_idx_q;
    acc_d         = acc_q | DRV_ACT;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    data_d        = data_q;
    ld_d          = ld_q;
    done_d        = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    case (state_q)
      IDLE: begin
        state_d = SNAP;
      end

      SNAP: begin
        shreg_d   = snap_bits;
        acc_d     = DRV_ACT;  // activity seen in this very cycle survives the clear
        bit_idx_d = '0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        if (tick_fall) begin
          data_d    = shreg_q[0];
          ld_d      = (bit_idx_q == '0);
          shreg_d   = {1'b0, shreg_q[NBITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_LAST) begin
            state_d = GAP;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end

      GAP: begin
        if (tick_fall) begin
          data_d      = 1'b0;
          ld_d        = 1'b0;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
          end else begin
            blink_cnt_d   = blink_cnt_q + BLK_W'(1);
          end
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_idx_q     <= '0;
      acc_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      data_q        <= 1'b0;
      ld_q          <= 1'b0;
      done_q        <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_idx_q     <= bit_idx_d;
      acc_q         <= acc_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      data_q        <= data_d;
      ld_q          <= ld_d;
      done_q        <= done_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign SGPIO_DATA = data_q;
  assign SGPIO_LD   = ld_q;
  assign FRAME_DONE = done_q;
  assign FRAME_CNT  = frame_cnt_q;

endmodule

// File: doc/bb_sgpio_ctrl.md
Name: bb_sgpio_ctrl

Overview:
- SGPIO frame controller for the baseboard CPLD. Drives the backplane SGPIO link for HDD_NUM drive bays.
- Generates SGPIO_CK, sequences snapshot, shift, load and gap phases, and produces 3 bits per drive (ACT, LOCATE, FAIL).
- Applies policy to the LED sources: sticky activity per frame, locate blink, global enable and lamp test.
- Sits between the drive-status sources and the backplane SGPIO pins.

Parameters:
- HDD_NUM, 36, number of drive bays; frame length is 3*HDD_NUM data bits.
- CLK_DIV, 250, SYSCLK cycles per SGPIO_CK half-period (50 MHz -> 100 kHz); must be >= 2.
- BLINK_FRAMES, 8, number of frames per locate-blink half-period.

Ports:
- SYSCLK  in  1  system clock.
- RESET  in  1  synchronous active-high reset.
- DRV_ACT  in  HDD_NUM  per-drive activity, asynchronous to frames, bit i = drive i.
- DRV_LOCATE  in  HDD_NUM  per-drive locate request (level).
- DRV_FAIL  in  HDD_NUM  per-drive fault (level).
- LED_EN  in  1  global LED enable.
- LAMP_TEST  in  1  forces every transmitted bit to 1.
- SGPIO_CK  out  1  SGPIO clock.
- SGPIO_LD  out  1  SGPIO load (frame marker).
- SGPIO_DATA  out  1  SGPIO serial data.
- FRAME_DONE  out  1  one-SYSCLK pulse at the end of each frame.
- FRAME_CNT  out  16  count of completed frames; wraps from 0xFFFF to 0.

Behaviour:
- Interface (already decided): one clock, SYSCLK; reset is synchronous and active-high, named RESET.
- Reset values: SGPIO_CK=0, SGPIO_LD=0, SGPIO_DATA=0, FRAME_DONE=0, FRAME_CNT=0, state=IDLE, blink phase=0, sticky ACT=0, divider=0, bit index=0.
- Reset asserted mid-frame aborts the frame. All of the above values appear on the first SYSCLK edge with RESET high.
- Clock generation:
  - Divider counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and SGPIO_CK toggles.
  - tick_fall is a one-cycle internal pulse in the cycle SGPIO_CK goes 1->0; tick_rise is the same for 0->1.
  - SGPIO_DATA and SGPIO_LD change only on tick_fall, so the target samples them stable on the rising edge.
- Sticky ACT: acc[i] is set whenever DRV_ACT[i]=1, and is copied into the snapshot and cleared in SNAP. If DRV_ACT[i]=1 in the SNAP cycle itself, acc[i] ends at 1 (set wins over clear).
- State IDLE: unconditionally goes to SNAP on the next cycle.
- State SNAP (1 cycle):
  - Loads a 3*HDD_NUM shift register.
  - Drive i maps to bits [3i]=ACT_eff, [3i+1]=LOCATE_eff, [3i+2]=FAIL_eff. Drive 0 ACT is shifted out first.
  - ACT_eff=acc[i]|DRV_ACT[i]; LOCATE_eff=DRV_LOCATE[i]&blink_phase; FAIL_eff=DRV_FAIL[i].
  - LED_EN=0 zeroes all bits. LAMP_TEST=1 sets all bits to 1 and overrides LED_EN.
  - Clears bit index; goes to SHIFT.
- State SHIFT:
  - On each tick_fall: SGPIO_DATA<=shreg[0], SGPIO_LD<=(bit_idx==0), shift right, bit_idx+1.
  - After driving bit_idx==3*HDD_NUM-1, goes to GAP.
  - No action between ticks.
- State GAP:
  - On tick_fall: SGPIO_DATA<=0, SGPIO_LD<=0, FRAME_DONE<=1 for that cycle, FRAME_CNT+1, and go to IDLE.
  - Blink update happens in the same cycle: a frame-modulo counter counts 0..BLINK_FRAMES-1 and toggles blink_phase on wrap.
- Frame period is 3*HDD_NUM+1 SGPIO clocks plus a sub-tick SNAP overhead. SNAP always completes before the next tick_fall because CLK_DIV >= 2.
- Input changes after SNAP affect the next frame only; no glitch reaches the current frame.
- Default state encoding falls back to IDLE.

Decomposition:
- Package bb_sgpio_pkg holds:
  - State encodings IDLE, SNAP, SHIFT, GAP.
  - Per-drive bit offsets ACT_OFS=0, LOC_OFS=1, FAIL_OFS=2, and BITS_PER_DRV=3.
  - Default values for CLK_DIV and BLINK_FRAMES.
- Sub-module bb_sgpio_clkgen (parameter CLK_DIV) holds the divider and SGPIO_CK toggle, and outputs SGPIO_CK, tick_rise and tick_fall.
- Sequencing, sticky ACT, blink and shift register stay in bb_sgpio_ctrl.

Test Plan (HDD_NUM=4, CLK_DIV=2, BLINK_FRAMES=2 unless noted):
- Reset release, all inputs 0, LED_EN=1 -> SGPIO_CK period 4 SYSCLK; 12 data bits all 0; LD=1 only on bit 0; FRAME_DONE pulses every 13 SGPIO clocks; FRAME_CNT increments 0,1,2.
- DRV_FAIL=4'b1000, DRV_ACT pulsed 1 cycle on drive 1 mid-frame -> next frame bits (bit0 first) = 000 100 000 001. The pulse is reported exactly once; the frame after is all 0.
- DRV_LOCATE=4'b0001 held -> bit1 = 0,0,1,1,0,0 over frames 0..5 (blink phase toggles every 2 frames).
- LED_EN=0 with all drive inputs 1 -> all-zero frames. Then LAMP_TEST=1 -> all 12 bits 1, overriding LED_EN=0.
- RESET pulsed 1 cycle during bit 5 -> next edge: CK/LD/DATA=0 and FRAME_CNT=0; the following frame restarts from bit 0 with LD=1.
- FRAME_CNT preloaded by forcing to 0xFFFF -> after next FRAME_DONE it reads 0x0000; DRV_ACT=1 held through SNAP -> ACT bit 1 in two consecutive frames.
